// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI responder with SCK/MOSI/SS synchronised into PCLK and valid/ready byte interfaces
//   Optional feature macro SPI_SLV_RXFIFO_EN: RX storage becomes a FIFO_DEPTH-entry FIFO (else one holding register).
//   Ports: PCLK/PRESET clock and asynchronous active-high reset; CPOL/CPHA mode, latched at SS fall;
//   SCK/MOSI/SS in, MISO/MISO_OE out; TXDATA/TXVALID/TXREADY transmit holding register;
//   RXDATA/RXVALID/RXREADY receive storage; RXOVR/TXUND one-cycle error pulses; BUSY while selected.
module spi_slave_core #(
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          CPOL,
  input  logic          CPHA,
  input  logic          SCK,
  input  logic          MOSI,
  input  logic          SS,
  output logic          MISO,
  output logic          MISO_OE,
  input  logic [DW-1:0] TXDATA,
  input  logic          TXVALID,
  output logic          TXREADY,
  output logic [DW-1:0] RXDATA,
  output logic          RXVALID,
  input  logic          RXREADY,
  output logic          RXOVR,
  output logic          TXUND,
  output logic          BUSY
);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic [1:0] sck_s, mosi_s, ss_s;
  logic sck_d, ss_d, cpol_l, cpha_l, drv, hold_full;
  logic [DW-1:0] tx_shift, rx_shift, tx_hold, rx_nx;
  logic [CW-1:0] bit_cnt;
  logic ss_fall, ss_rise, act, rise, fall, lead, trail, samp, shft;
  logic push, start, reload, consume, load, pop, wr;
  assign ss_fall = ss_d & ~ss_s[1];
  assign ss_rise = ~ss_d & ss_s[1];
  assign rise = ~sck_d & sck_s[1];
  assign fall = sck_d & ~sck_s[1];
  assign act = state == ACTIVE && !ss_rise;
  assign lead = act && (cpol_l ? fall : rise);
  assign trail = act && (cpol_l ? rise : fall);
  assign samp = cpha_l ? trail : lead;
  assign shft = cpha_l ? lead : trail;
  assign push = samp && bit_cnt == LAST;
  assign start = state == IDLE && ss_fall;
  // CPHA=0 reloads on the trailing edge that follows the wrap; CPHA=1 reloads at the last sample
  assign reload = cpha_l ? push : trail && bit_cnt == '0;
  assign consume = start || reload;
  assign load = TXVALID && !hold_full;
  assign pop = RXVALID && RXREADY;
  assign rx_nx = {rx_shift[DW-2:0], mosi_s[1]};
  assign BUSY = state == ACTIVE;
  assign MISO_OE = BUSY;
  // CPHA=1 holds MISO low until the first leading edge of the selection
  assign MISO = BUSY && (!cpha_l || drv) && tx_shift[DW-1];
  assign TXREADY = !hold_full;
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (ss_fall ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      sck_s <= '0;
      mosi_s <= '0;
      ss_s <= '0;
      sck_d <= 1'b0;
      ss_d <= 1'b0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      drv <= 1'b0;
      hold_full <= 1'b0;
      tx_hold <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      RXOVR <= 1'b0;
      TXUND <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], SCK};
      mosi_s <= {mosi_s[0], MOSI};
      ss_s <= {ss_s[0], SS};
      sck_d <= sck_s[1];
      ss_d <= ss_s[1];
      if (start) begin
        cpol_l <= CPOL;
        cpha_l <= CPHA;
      end
      drv <= (start || ss_rise) ? 1'b0 : (drv || lead);
      if (start || ss_rise) bit_cnt <= '0;
      else if (samp) bit_cnt <= push ? '0 : bit_cnt + 1'b1;
      if (samp) rx_shift <= rx_nx;
      // the first CPHA=1 leading edge of a frame presents the MSB instead of shifting it out
      if (consume) tx_shift <= hold_full ? tx_hold : '0;
      else if (shft && !(cpha_l && bit_cnt == '0)) tx_shift <= tx_shift << 1;
      if (load) tx_hold <= TXDATA;
      hold_full <= load || (hold_full && !consume);
      TXUND <= consume && !hold_full;
      RXOVR <= push && !wr;
    end
`ifdef SPI_SLV_RXFIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [NW-1:0] cnt;
  assign wr = push && (cnt != NW'(FIFO_DEPTH) || pop);
  assign RXVALID = cnt != '0;
  assign RXDATA = mem[rp];
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= rx_nx;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + NW'(wr) - NW'(pop);
    end
`else
  assign wr = push && (!RXVALID || RXREADY);
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      RXVALID <= 1'b0;
      RXDATA <= '0;
    end else begin
      RXVALID <= wr || (RXVALID && !pop);
      if (wr) RXDATA <= rx_nx;
    end
`endif
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed SPI master stimulus against a transaction-level model of spi_slave_core
module tb_spi_slave_core;
  localparam int H = 8;
`ifdef SPI_SLV_RXFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic PCLK = 0, PRESET = 0, CPOL = 0, CPHA = 0, SCK = 0, MOSI = 0, SS = 1;
  logic TXVALID = 0, RXREADY = 1;
  logic [7:0] TXDATA = 0;
  logic [7:0] RXDATA;
  logic MISO, MISO_OE, TXREADY, RXVALID, RXOVR, TXUND, BUSY;
  int n_chk = 0, n_fail = 0, ovr_seen = 0, und_seen = 0, exp_ovr = 0, exp_und = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hold = 0, nxt = 0, last_rx = 0, last_mi = 0;
  logic hold_v = 0, sel = 0;

  always #5 PCLK = ~PCLK;

  spi_slave_core dut (
    .PCLK(PCLK), .PRESET(PRESET), .CPOL(CPOL), .CPHA(CPHA), .SCK(SCK), .MOSI(MOSI), .SS(SS),
    .MISO(MISO), .MISO_OE(MISO_OE), .TXDATA(TXDATA), .TXVALID(TXVALID), .TXREADY(TXREADY),
    .RXDATA(RXDATA), .RXVALID(RXVALID), .RXREADY(RXREADY), .RXOVR(RXOVR), .TXUND(TXUND), .BUSY(BUSY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  always @(negedge PCLK) if (!PRESET) begin
    check("oe_eq_busy", 32'(MISO_OE), 32'(BUSY));
    if (!MISO_OE) check("miso_idle_low", 32'(MISO), 0);
    if (RXOVR) ovr_seen++;
    if (TXUND) und_seen++;
    if (RXVALID && RXREADY) begin
      check("rx_pop_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("rx_data", 32'(RXDATA), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      last_rx = RXDATA;
    end
  end

  task automatic take(output logic [7:0] v);
    if (hold_v) begin
      v = hold;
      hold_v = 0;
    end else begin
      v = 0;
      exp_und++;
    end
  endtask

  task automatic chk_reset(input string name);
    check(name, 32'({MISO, MISO_OE, TXREADY, RXVALID, RXOVR, TXUND, BUSY, RXDATA}), 32'(15'b0010000_00000000));
  endtask

  task automatic mode(input logic p, input logic h);
    CPOL = p;
    CPHA = h;
    SCK = p;
    cyc(H);
  endtask

  task automatic tx_load(input logic [7:0] b);
    check("txready_before_load", 32'(TXREADY), 32'(!hold_v));
    TXDATA = b;
    TXVALID = 1;
    cyc(1);
    TXVALID = 0;
    hold = b;
    hold_v = 1;
    check("txready_after_load", 32'(TXREADY), 0);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nb);
    logic [7:0] mi, emi;
    logic m4;
    int unst;
    mi = 0;
    unst = 0;
    if (nb == 8) begin
      if (exp_q.size() < CAP) exp_q.push_back(mo);
      else exp_ovr++;
    end
    if (!sel) begin
      take(emi);
      sel = 1;
    end else emi = nxt;
    SCK = CPOL;
    cyc(H);
    SS = 0;
    cyc(H);
    for (int i = 0; i < nb; i++) begin
      if (!CPHA) MOSI = mo[7-i];
      cyc(H/2);
      m4 = MISO;
      cyc(H/2);
      SCK = ~CPOL;
      if (!CPHA) begin
        mi = {mi[6:0], MISO};
        unst += int'(m4 != MISO);
      end else MOSI = mo[7-i];
      cyc(H/2);
      m4 = MISO;
      cyc(H/2);
      SCK = CPOL;
      if (CPHA) begin
        mi = {mi[6:0], MISO};
        unst += int'(m4 != MISO);
      end
    end
    cyc(H);
    if (nb == 8) begin
      take(nxt);
      last_mi = mi;
      check("miso_byte", 32'(mi), 32'(emi));
      check("miso_stable_at_sample", 32'(unst), 0);
      check("txready_after_frame", 32'(TXREADY), 32'(!hold_v));
    end
  endtask

  task automatic ss_up();
    cyc(H);
    SS = 1;
    sel = 0;
    cyc(2*H);
  endtask

  task automatic settle();
    cyc(10);
    check("rxovr_count", 32'(ovr_seen), 32'(exp_ovr));
    check("txund_count", 32'(und_seen), 32'(exp_und));
    if (RXREADY) check("rx_all_delivered", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1 PRESET = 1;
    cyc(3);
    chk_reset("reset_outputs");
    PRESET = 0;
    cyc(3);
    mode(0, 0);
    tx_load(8'hA5);
    xfer(8'h56, 8);
    ss_up();
    settle();
    check("t1_rx_literal", 32'(last_rx), 32'h56);
    check("t1_miso_literal", 32'(last_mi), 32'hA5);
    check("t1_txund_literal", 32'(und_seen), 1);
    for (int m = 1; m < 4; m++) begin
      mode(m[1], m[0]);
      tx_load(8'h3C);
      xfer(8'h83, 8);
      ss_up();
      settle();
      check("t2_rx_literal", 32'(last_rx), 32'h83);
      check("t2_miso_literal", 32'(last_mi), 32'h3C);
    end
    mode(0, 0);
    RXREADY = 0;
    xfer(8'h83, 8);
    xfer(8'hA3, 8);
    ss_up();
    settle();
    check("t3_rxdata_head", 32'(RXDATA), 32'h83);
    check("t3_rxvalid_held", 32'(RXVALID), 1);
    RXREADY = 1;
    settle();
    RXREADY = 0;
    xfer(8'h11, 8); ss_up();
    xfer(8'h22, 8); ss_up();
    xfer(8'h33, 8); ss_up();
    xfer(8'h44, 8); ss_up();
    xfer(8'h5C, 8); ss_up();
    settle();
    check("t3_ovr_literal", 32'(ovr_seen), CAP == 1 ? 5 : 1);
    RXREADY = 1;
    settle();
    xfer(8'h6E, 8);
    ss_up();
    settle();
    check("t4_underrun_reads_zero", 32'(last_mi), 0);
    xfer(8'hAD, 4);
    ss_up();
    check("t5_busy_low", 32'(BUSY), 0);
    check("t5_oe_low", 32'(MISO_OE), 0);
    check("t5_no_rxvalid", 32'(RXVALID), 0);
    tx_load(8'h96);
    xfer(8'h48, 8);
    ss_up();
    settle();
    check("t5_rx_literal", 32'(last_rx), 32'h48);
    check("t5_miso_literal", 32'(last_mi), 32'h96);
    mode(0, 1);
    xfer(8'h32, 5);
    tx_load(8'h99);
    PRESET = 1;
    cyc(2);
    chk_reset("t6_reset_outputs");
    PRESET = 0;
    hold_v = 0;
    sel = 0;
    exp_q.delete();
    cyc(2);
    SS = 1;
    cyc(2*H);
    tx_load(8'hC3);
    xfer(8'h5C, 8);
    ss_up();
    settle();
    check("t6_rx_literal", 32'(last_rx), 32'h5C);
    check("t6_miso_literal", 32'(last_mi), 32'hC3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
